reg_file_scoreboard: RTL and testbench

- Register file and busy scoreboard answering the decode stage's operand requests.
- Decode presents two source register indices and a next-destination index. This block returns the operand values plus an in-use flag per operand, one clock later.
- The execute/writeback stage writes results back through a single write port, which clears pending state.
- A per-register pending-write counter lets several in-flight writes to the same register be tracked. Any consumer stays marked in-use until the last of those writes retires.

---
 rtl/reg_file_scoreboard.sv | 87 ++++++++
 tb/tb_reg_file_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write scoreboard.
// Decode reads two operands (value + in-use flag) with one cycle of latency;
// writeback writes one register per cycle and retires one pending write.
module reg_file_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcReg1,
  input  logic [ADDR_W-1:0] srcReg2,
  input  logic [ADDR_W-1:0] nextDestReg,
  input  logic              issueValid,
  output logic              issueStall,
  input  logic              wbValid,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0] wbVal,
  output logic [DATA_W-1:0] srcRegVal1,
  output logic [DATA_W-1:0] srcRegVal2,
  output logic              inuse1,
  output logic              inuse2
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [PEND_W-1:0] pend [NREG];

  logic              hit1, hit2;
  logic [PEND_W-1:0] rem1, rem2;
  logic [NREG-1:0]   incVec, decVec;

  // A saturated counter blocks further issue; deliberately ignores a
  // same-cycle writeback that would free a slot.
  assign issueStall = (pend[nextDestReg] == PEND_MAX);

  // Operand lookup: bypass same-cycle writeback data and count the retiring
  // write as already gone when deciding in-use.
  always_comb begin
    hit1 = wbValid && (wbReg == srcReg1);
    hit2 = wbValid && (wbReg == srcReg2);
    rem1 = pend[srcReg1];
    rem2 = pend[srcReg2];
    if (hit1 && (rem1 != '0)) rem1 = rem1 - PEND_ONE;
    if (hit2 && (rem2 != '0)) rem2 = rem2 - PEND_ONE;
  end

  // Per-register increment/decrement requests for the pending counters.
  always_comb begin
    incVec = '0;
    decVec = '0;
    for (int r = 0; r < NREG; r++) begin
      incVec[r] = issueValid && !issueStall && (nextDestReg == ADDR_W'(r));
      decVec[r] = wbValid && (wbReg == ADDR_W'(r)) && (pend[r] != '0);
    end
  end

  // State update: storage, pending counters and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      srcRegVal1 <= '0;
      srcRegVal2 <= '0;
      inuse1     <= 1'b0;
      inuse2     <= 1'b0;
    end else begin
      if (wbValid) regs[wbReg] <= wbVal;
      for (int r = 0; r < NREG; r++) begin
        if (incVec[r] && !decVec[r])
          pend[r] <= pend[r] + PEND_ONE;
        else if (decVec[r] && !incVec[r])
          pend[r] <= pend[r] - PEND_ONE;
      end
      srcRegVal1 <= hit1 ? wbVal : regs[srcReg1];
      srcRegVal2 <= hit2 ? wbVal : regs[srcReg2];
      inuse1     <= (rem1 != '0);
      inuse2     <= (rem2 != '0);
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: fixed vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  srcReg1, srcReg2, nextDestReg, wbReg;
  logic        issueValid, wbValid;
  logic [15:0] wbVal;
  logic        issueStall;
  logic [15:0] srcRegVal1, srcRegVal2;
  logic        inuse1, inuse2;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int unsigned mRegs [16];
  int          mPend [16];
  int unsigned expVal1, expVal2;
  bit          expIn1, expIn2, expStall;
  logic        stallSeen;

  typedef struct {
    logic        r;
    logic [3:0]  s1, s2, nd;
    logic        iv, wv;
    logic [3:0]  wr;
    logic [15:0] wd;
    logic        eStall;
    logic [15:0] eV1, eV2;
    logic        eI1, eI2;
  } vec_t;

  vec_t tv [14];

  reg_file_scoreboard dut (
    .clk(clk), .rst(rst),
    .srcReg1(srcReg1), .srcReg2(srcReg2),
    .nextDestReg(nextDestReg), .issueValid(issueValid), .issueStall(issueStall),
    .wbValid(wbValid), .wbReg(wbReg), .wbVal(wbVal),
    .srcRegVal1(srcRegVal1), .srcRegVal2(srcRegVal2),
    .inuse1(inuse1), .inuse2(inuse2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] s1, s2, nd,
                              input logic iv, wv, input logic [3:0] wr,
                              input logic [15:0] wd, input logic eStall,
                              input logic [15:0] eV1, eV2, input logic eI1, eI2);
    vec_t v;
    v.r = r; v.s1 = s1; v.s2 = s2; v.nd = nd; v.iv = iv; v.wv = wv;
    v.wr = wr; v.wd = wd; v.eStall = eStall;
    v.eV1 = eV1; v.eV2 = eV2; v.eI1 = eI1; v.eI2 = eI2;
    return v;
  endfunction

  // Drive one cycle, sample the combinational stall before the edge,
  // advance the model, then return 1 time unit after the edge.
  task automatic doCycle(input logic r, input logic [3:0] a1, a2, nd,
                         input logic iv, wv, input logic [3:0] wr,
                         input logic [15:0] wd);
    int outstanding;
    bit inc;
    rst = r; srcReg1 = a1; srcReg2 = a2; nextDestReg = nd;
    issueValid = iv; wbValid = wv; wbReg = wr; wbVal = wd;
    #1;
    stallSeen = issueStall;
    expStall = (mPend[nd] == 3);
    if (r) begin
      for (int i = 0; i < 16; i++) begin mRegs[i] = 0; mPend[i] = 0; end
      expVal1 = 0; expVal2 = 0; expIn1 = 0; expIn2 = 0;
    end else begin
      expVal1 = (wv && wr == a1) ? wd : mRegs[a1];
      expVal2 = (wv && wr == a2) ? wd : mRegs[a2];
      outstanding = mPend[a1];
      if (wv && wr == a1 && outstanding > 0) outstanding--;
      expIn1 = outstanding > 0;
      outstanding = mPend[a2];
      if (wv && wr == a2 && outstanding > 0) outstanding--;
      expIn2 = outstanding > 0;
      inc = iv && (mPend[nd] < 3);
      if (wv) begin
        mRegs[wr] = wd;
        if (mPend[wr] > 0) mPend[wr]--;
      end
      if (inc) mPend[nd]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = mk(0, 5, 5, 0, 0, 1, 5, 16'h1234, 0, 16'h1234, 16'h1234, 0, 0);
    tv[1]  = mk(0, 5, 2, 2, 1, 0, 0, 16'h0000, 0, 16'h1234, 16'h0000, 0, 0);
    tv[2]  = mk(0, 2, 5, 2, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 0);
    tv[3]  = mk(0, 2, 2, 2, 1, 1, 2, 16'hBEEF, 0, 16'hBEEF, 16'hBEEF, 1, 1);
    tv[4]  = mk(0, 2, 7, 2, 1, 0, 0, 16'h0000, 0, 16'hBEEF, 16'h0000, 1, 0);
    tv[5]  = mk(0, 2, 2, 2, 1, 0, 0, 16'h0000, 1, 16'hBEEF, 16'hBEEF, 1, 1);
    tv[6]  = mk(0, 2, 0, 2, 0, 1, 2, 16'h0001, 1, 16'h0001, 16'h0000, 1, 0);
    tv[7]  = mk(0, 2, 2, 0, 0, 1, 2, 16'h0002, 0, 16'h0002, 16'h0002, 1, 1);
    tv[8]  = mk(0, 2, 3, 3, 1, 1, 2, 16'h0003, 0, 16'h0003, 16'h0000, 0, 0);
    tv[9]  = mk(0, 3, 2, 0, 0, 1, 0, 16'h00AA, 0, 16'h0000, 16'h0003, 1, 0);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h00AA, 16'h00AA, 0, 0);
    tv[11] = mk(1, 3, 5, 3, 1, 1, 3, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0);
    tv[12] = mk(0, 5, 0, 3, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    tv[13] = mk(0, 3, 2, 3, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < 16; i++) begin mRegs[i] = 0; mPend[i] = 0; end

    // reset state
    doCycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
    doCycle(1, 0, 0, 0, 1, 1, 0, 16'hFFFF);
    chk("reset val1", srcRegVal1, 16'h0);
    chk("reset val2", srcRegVal2, 16'h0);
    chk("reset in1", inuse1, 1'b0);
    chk("reset in2", inuse2, 1'b0);

    // fixed vector table
    for (int i = 0; i < 14; i++) begin
      doCycle(tv[i].r, tv[i].s1, tv[i].s2, tv[i].nd, tv[i].iv, tv[i].wv, tv[i].wr, tv[i].wd);
      chk($sformatf("vec%0d stall", i), stallSeen, tv[i].eStall);
      chk($sformatf("vec%0d val1", i), srcRegVal1, tv[i].eV1);
      chk($sformatf("vec%0d val2", i), srcRegVal2, tv[i].eV2);
      chk($sformatf("vec%0d in1", i), inuse1, tv[i].eI1);
      chk($sformatf("vec%0d in2", i), inuse2, tv[i].eI2);
    end

    // saturation on R7: fourth issue ignored, retire three writes
    doCycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      doCycle(0, 7, 7, 7, 1, 0, 0, 16'h0);
      chk($sformatf("r7 issue%0d stall", k), stallSeen, 1'b0);
    end
    doCycle(0, 7, 7, 7, 1, 0, 0, 16'h0);
    chk("r7 full stall", stallSeen, 1'b1);
    chk("r7 full in1", inuse1, 1'b1);
    doCycle(0, 7, 7, 7, 0, 1, 7, 16'h0701);
    chk("r7 wb1 in1", inuse1, 1'b1);
    chk("r7 wb1 val1", srcRegVal1, 16'h0701);
    doCycle(0, 7, 7, 7, 0, 1, 7, 16'h0702);
    chk("r7 wb2 in1", inuse1, 1'b1);
    doCycle(0, 7, 7, 7, 0, 0, 0, 16'h0);
    chk("r7 after2 in1", inuse1, 1'b1);
    chk("r7 after2 val1", srcRegVal1, 16'h0702);
    doCycle(0, 7, 7, 7, 0, 1, 7, 16'h0703);
    chk("r7 wb3 in1", inuse1, 1'b0);
    chk("r7 wb3 val1", srcRegVal1, 16'h0703);
    doCycle(0, 7, 7, 7, 0, 0, 0, 16'h0);
    chk("r7 idle in1", inuse1, 1'b0);
    chk("r7 idle stall", stallSeen, 1'b0);

    // same-cycle issue + writeback on R4 with one pending write
    doCycle(0, 4, 4, 4, 1, 0, 0, 16'h0);
    chk("r4 selfread in1", inuse1, 1'b0);
    doCycle(0, 4, 4, 4, 1, 1, 4, 16'h4444);
    chk("r4 both val1", srcRegVal1, 16'h4444);
    chk("r4 both in1", inuse1, 1'b0);
    doCycle(0, 4, 4, 0, 0, 0, 0, 16'h0);
    chk("r4 next val1", srcRegVal1, 16'h4444);
    chk("r4 next in1", inuse1, 1'b1);
    doCycle(0, 4, 4, 0, 0, 1, 4, 16'h0000);
    chk("r4 clear in1", inuse1, 1'b0);

    // reset mid-flight discards a coincident writeback to R9
    doCycle(0, 9, 9, 9, 1, 0, 0, 16'h0);
    doCycle(0, 9, 9, 9, 1, 0, 0, 16'h0);
    chk("r9 pend in1", inuse1, 1'b1);
    doCycle(1, 9, 9, 9, 0, 1, 9, 16'h5555);
    chk("r9 rst val1", srcRegVal1, 16'h0);
    chk("r9 rst in1", inuse1, 1'b0);
    doCycle(0, 9, 9, 9, 0, 0, 0, 16'h0);
    chk("r9 after val1", srcRegVal1, 16'h0);
    chk("r9 after in1", inuse1, 1'b0);
    chk("r9 after stall", stallSeen, 1'b0);

    // randomized traffic against the model, biased to a few hot registers
    for (int n = 0; n < 600; n++) begin
      logic [3:0] a1, a2, nd, wr;
      a1 = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      a2 = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      nd = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      wr = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      doCycle($urandom_range(0, 63) == 0, a1, a2, nd,
              $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, wr,
              16'($urandom));
      chk($sformatf("rnd%0d stall", n), stallSeen, expStall);
      chk($sformatf("rnd%0d val1", n), srcRegVal1, expVal1);
      chk($sformatf("rnd%0d val2", n), srcRegVal2, expVal2);
      chk($sformatf("rnd%0d in1", n), inuse1, expIn1);
      chk($sformatf("rnd%0d in2", n), inuse2, expIn2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
